fifo_rd_ptr_ctrl: RTL and testbench
===================================

// Module: fifo_rd_ptr_ctrl
// PURPOSE
//  Read-side pointer controller for the UART->processor async FIFO, in processor_clk domain.
//  Owns the read pointer; synchronises the write-domain gray pointer over N stages.
//  Produces registered empty / almost_empty / fill level, plus a gray read pointer for the write side.
//  Parametrised successor of the fixed-width empty comparator.
//  Adds depth/width generics, a configurable sync depth, wrap-bit pointers, level and threshold flags.
// PARAMETERS
//  ADDR_W       3  RAM address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits (MSB = wrap bit)
//  SYNC_STAGES  2  synchroniser flops on w_ptr_gray; legal range 2..4; elaboration $error otherwise
//  AE_THRESH    1  almost_empty asserted when level <= AE_THRESH; legal range 0..DEPTH-1
// PORTS
//  processor_clk  in   1         read-domain clock; the only clock
//  reset          in   1         asynchronous, active-high
//  w_ptr_gray     in   ADDR_W+1  write pointer, gray coded; registered in the write domain
//  rd_en          in   1         read request; accepted only when empty==0
//  rd_addr        out  ADDR_W    RAM read address = rd_ptr[ADDR_W-1:0]
//  rd_ptr_gray    out  ADDR_W+1  registered gray of rd_ptr; crosses to the write side
//  empty          out  1         registered; 1 = no readable entries
//  almost_empty   out  1         registered; level <= AE_THRESH
//  level          out  ADDR_W+1  registered occupancy, 0..DEPTH
//  underflow_err  out  1         FIFO_UNDERFLOW_ERR_EN only; sticky
//  underflow_clr  in   1         FIFO_UNDERFLOW_ERR_EN only; synchronous clear of underflow_err
// BEHAVIOUR
//  Reset:
//   - sync chain, rd_ptr, rd_ptr_gray, level and underflow_err go to 0.
//   - empty and almost_empty go to 1.
//   - reset is asserted asynchronously; a read in flight is discarded.
//  Accept:
//   - rd_acc = rd_en & ~empty.
//   - rd_ptr_nxt = rd_ptr + rd_acc, modulo 2**(ADDR_W+1). Wrap is natural; no special case.
//  Sync and decode:
//   - w_sync = last stage of the sync chain.
//   - wptr_bin = gray2bin(w_sync), combinational, after the chain only.
//  Status, all registered from next-state values:
//   - level <= wptr_bin - rd_ptr_nxt (ADDR_W+1-bit modular subtraction).
//   - empty <= (bin2gray(rd_ptr_nxt) == w_sync).
//   - almost_empty <= (wptr_bin - rd_ptr_nxt) <= AE_THRESH.
//   - rd_ptr_gray <= bin2gray(rd_ptr_nxt).
//  Latency:
//   - w_ptr_gray change -> empty/level update: exactly SYNC_STAGES+1 processor_clk edges.
//   - rd_acc -> empty/level/rd_ptr_gray update: the next edge.
//  Flag rules:
//   - Full level (DEPTH) is distinguished from empty (0) by the pointer MSB.
//   - empty is pessimistic. It may stay 1 while writes propagate; it never reads 0 with level==0.
//  Boundaries:
//   - Simultaneous rd_acc and sync'd write advance: both apply in the same update; level reflects both.
//   - Last entry read (level 1 + rd_acc, no new write): empty=1, level=0 next edge.
//   - rd_en while empty: pointer unchanged; no output change except underflow_err.
// CONFIGURATION
//  FIFO_UNDERFLOW_ERR_EN defined:
//   - underflow_err is set on (rd_en & empty) and held until underflow_clr or reset.
//   - If set and clr occur in the same cycle, set wins.
//  Undefined:
//   - both ports are absent; rd_en while empty is silently ignored.
// STRUCTURE
//  DataTypes package gains:
//   - functions bin2gray / gray2bin, parametrised by width via a parametrised class or width arg.
//   - default constants FIFO_ADDR_W_DEF=3 and FIFO_SYNC_STAGES_DEF=2.
//  One sub-module: sync_chain_n (params WIDTH, STAGES; processor_clk, reset, d, q).
//   - plain flop shift chain, reset to 0.
//  Everything else is in this module.
// TESTING (ADDR_W=3, SYNC_STAGES=2, AE_THRESH=1 unless noted)
//  1 Reset asserted mid-cycle:
//     - outputs go immediately to empty=1, almost_empty=1, level=0, rd_addr=0, rd_ptr_gray=0.
//  2 w_ptr_gray 0->4'b0001 at edge k:
//     - empty=1 through edge k+2; empty=0 and level=1 after edge k+3; almost_empty stays 1.
//  3 w_ptr_gray=4'b0011 (bin 2), settled, then rd_en held 3 cycles:
//     - level 2->1->0; empty=1 after the 2nd accepted read; 3rd read is ignored.
//     - the 3rd read sets underflow_err under FIFO_UNDERFLOW_ERR_EN.
//  4 w_ptr_gray=4'b1100 (bin 8), settled, rd_ptr=0:
//     - level=8, empty=0, almost_empty=0.
//     - 8 reads then give rd_addr 0..7 and 0, rd_ptr_gray=4'b1100, empty=1.
//  5 Wrap: stream 20 writes/reads with rd_en and pointer steps in the same cycles:
//     - level never exceeds 8; no false empty deassert; rd_ptr wraps 15->0.
//  6 underflow_clr pulse with no concurrent rd_en-while-empty: underflow_err=0 next edge.
//     - clr with a concurrent underflow: err stays 1.

Source files
------------

// File: rtl/fifo_rd_ptr_ctrl_pkg.sv
// rtl/fifo_rd_ptr_ctrl_pkg.sv - default constants and gray/binary helpers for the read-pointer controller
package fifo_rd_ptr_ctrl_pkg;

    localparam int FIFO_ADDR_W_DEF      = 3;
    localparam int FIFO_SYNC_STAGES_DEF = 2;
    localparam int FIFO_AE_THRESH_DEF   = 1;

    function automatic logic [31:0] width_mask(input int unsigned w);
        return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
        return (b ^ (b >> 1)) & width_mask(w);
    endfunction

    // Prefix XOR from the MSB down; bits above w are masked so they cannot leak in.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
        logic [31:0] g_m;
        logic [31:0] b;
        g_m   = g & width_mask(w);
        b     = '0;
        b[31] = g_m[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g_m[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ptr_ctrl_if.sv
// rtl/fifo_rd_ptr_ctrl_if.sv - read-side FIFO pointer bus; underflow ports exist only with FIFO_UNDERFLOW_ERR_EN
interface fifo_rd_ptr_ctrl_if
    import fifo_rd_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W_DEF
);
    logic [ADDR_W:0]   w_ptr_gray;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_ptr_gray;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
`ifdef FIFO_UNDERFLOW_ERR_EN
    logic              underflow_err;
    logic              underflow_clr;
`endif

    modport master (
        output w_ptr_gray, rd_en,
`ifdef FIFO_UNDERFLOW_ERR_EN
        output underflow_clr,
        input  underflow_err,
`endif
        input  rd_addr, rd_ptr_gray, empty, almost_empty, level
    );

    modport slave (
        input  w_ptr_gray, rd_en,
`ifdef FIFO_UNDERFLOW_ERR_EN
        input  underflow_clr,
        output underflow_err,
`endif
        output rd_addr, rd_ptr_gray, empty, almost_empty, level
    );

endinterface

// File: rtl/fifo_rd_ptr_ctrl_sync_chain_n.sv
// rtl/fifo_rd_ptr_ctrl_sync_chain_n.sv - N-stage flop synchroniser, reset to zero
module sync_chain_n #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             processor_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge processor_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// rtl/fifo_rd_ptr_ctrl.sv - async FIFO read pointer, synced write pointer, registered flags/level
// Optional sticky underflow flag is built only with FIFO_UNDERFLOW_ERR_EN defined.
module fifo_rd_ptr_ctrl
    import fifo_rd_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_W      = FIFO_ADDR_W_DEF,
    parameter int SYNC_STAGES = FIFO_SYNC_STAGES_DEF,
    parameter int AE_THRESH   = FIFO_AE_THRESH_DEF
) (
    input  logic             processor_clk,
    input  logic             reset,
    fifo_rd_ptr_ctrl_if.slave bus
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("fifo_rd_ptr_ctrl: SYNC_STAGES must be 2..4");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_rd_ptr_ctrl: AE_THRESH must be 0..DEPTH-1");
    end

    logic [PW-1:0] w_sync;
    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          empty_q, ae_q;
    logic          rd_acc;

    sync_chain_n #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wsync (
        .processor_clk (processor_clk),
        .reset         (reset),
        .d             (bus.w_ptr_gray),
        .q             (w_sync)
    );

    // Status is computed from the post-read pointer so a read and a write landing together both count.
    always_comb begin
        wptr_bin  = PW'(gray2bin(32'(w_sync), PW));
        rd_acc    = bus.rd_en & ~empty_q;
        rd_ptr_d  = rd_ptr_q + PW'(rd_acc);
        rd_gray_d = PW'(bin2gray(32'(rd_ptr_d), PW));
        level_d   = wptr_bin - rd_ptr_d;
    end

    always_ff @(posedge processor_clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            rd_gray_q <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            rd_gray_q <= rd_gray_d;
            level_q   <= level_d;
            empty_q   <= (rd_gray_d == w_sync);
            ae_q      <= (level_d <= AE_T);
        end
    end

    assign bus.rd_addr      = rd_ptr_q[ADDR_W-1:0];
    assign bus.rd_ptr_gray  = rd_gray_q;
    assign bus.level        = level_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;

`ifdef FIFO_UNDERFLOW_ERR_EN
    logic uf_q;

    // A new underflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge processor_clk or posedge reset) begin
        if (reset) begin
            uf_q <= 1'b0;
        end else begin
            uf_q <= (bus.rd_en & empty_q) | (uf_q & ~bus.underflow_clr);
        end
    end

    assign bus.underflow_err = uf_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// tb/tb_fifo_rd_ptr_ctrl.sv - randomized self-checking bench for fifo_rd_ptr_ctrl against an occupancy model
module tb_fifo_rd_ptr_ctrl;

    localparam int ADDR_W = 3;
    localparam int SS     = 2;
    localparam int AE     = 1;
    localparam int DEPTH  = 8;

    logic processor_clk = 1'b0;
    logic reset         = 1'b1;

    fifo_rd_ptr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_rd_ptr_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
        .processor_clk (processor_clk),
        .reset         (reset),
        .bus           (bus.slave)
    );

    always #5 processor_clk = ~processor_clk;

    int n_cmp = 0;
    int n_mis = 0;

    int m_wc, m_rd, m_level;
    bit m_empty, m_ae, m_err;
    int wq[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wc = 0; m_rd = 0; m_level = 0;
        m_empty = 1; m_ae = 1; m_err = 0;
        wq = {};
        repeat (SS) wq.push_back(0);
    endtask

    task automatic drive(input bit rd, input int wc, input bit clr);
        m_wc = wc & 15;
        bus.rd_en      = rd;
        bus.w_ptr_gray = 4'(gray(m_wc));
`ifdef FIFO_UNDERFLOW_ERR_EN
        bus.underflow_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    // One clock: apply inputs, advance the occupancy model, compare on the falling edge.
    task automatic step(input bit rd, input int wc, input bit clr);
        int  w_vis;
        bit  acc;
        drive(rd, wc, clr);
        @(posedge processor_clk);
        w_vis = wq.pop_front();
        wq.push_back(m_wc);
        acc = rd && !m_empty;
        if (rd && m_empty) m_err = 1;
        else if (clr)      m_err = 0;
        m_rd    = (m_rd + int'(acc)) & 15;
        m_level = (w_vis - m_rd) & 15;
        m_empty = (m_level == 0);
        m_ae    = (m_level <= AE);
        @(negedge processor_clk);
        check_eq("empty", bus.empty, m_empty);
        check_eq("almost_empty", bus.almost_empty, m_ae);
        check_eq("level", bus.level, m_level);
        check_eq("rd_addr", bus.rd_addr, m_rd & 7);
        check_eq("rd_ptr_gray", bus.rd_ptr_gray, gray(m_rd));
        check_eq("level_le_depth", bus.level <= DEPTH, 1);
`ifdef FIFO_UNDERFLOW_ERR_EN
        check_eq("underflow_err", bus.underflow_err, m_err);
`endif
    endtask

    initial begin
        int wc;
        bit rd, inc, clr;
        model_reset();
        drive(0, 0, 0);
        repeat (3) @(posedge processor_clk);
        @(negedge processor_clk);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_ae", bus.almost_empty, 1);
        check_eq("rst_level", bus.level, 0);
        check_eq("rst_addr", bus.rd_addr, 0);
        check_eq("rst_gray", bus.rd_ptr_gray, 0);
        reset = 1'b0;

        // Write pointer 0 -> 1 shows up after exactly SS+1 edges
        step(0, 1, 0);
        check_eq("t2_empty_k1", bus.empty, 1);
        step(0, 1, 0);
        check_eq("t2_empty_k2", bus.empty, 1);
        step(0, 1, 0);
        check_eq("t2_empty_k3", bus.empty, 0);
        check_eq("t2_level_k3", bus.level, 1);
        check_eq("t2_ae_k3", bus.almost_empty, 1);

        // Two entries, three reads: last one ignored
        repeat (3) step(0, 2, 0);
        check_eq("t3_level2", bus.level, 2);
        step(1, 2, 0);
        check_eq("t3_level1", bus.level, 1);
        check_eq("t3_empty1", bus.empty, 0);
        step(1, 2, 0);
        check_eq("t3_level0", bus.level, 0);
        check_eq("t3_empty0", bus.empty, 1);
        step(1, 2, 0);
        check_eq("t3_addr_hold", bus.rd_addr, 2);
`ifdef FIFO_UNDERFLOW_ERR_EN
        check_eq("t3_uf_set", bus.underflow_err, 1);
        step(0, 2, 1);
        check_eq("t6_uf_clr", bus.underflow_err, 0);
        step(1, 2, 1);
        check_eq("t6_uf_set_wins", bus.underflow_err, 1);
`endif

        // Mid-cycle asynchronous reset
        step(0, 3, 0);
        step(0, 3, 0);
        @(posedge processor_clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_empty", bus.empty, 1);
        check_eq("mrst_ae", bus.almost_empty, 1);
        check_eq("mrst_level", bus.level, 0);
        check_eq("mrst_addr", bus.rd_addr, 0);
        check_eq("mrst_gray", bus.rd_ptr_gray, 0);
        model_reset();
        drive(0, 0, 0);
        @(negedge processor_clk);
        reset = 1'b0;

        // Full FIFO: wrap bit distinguishes level 8 from 0
        repeat (3) step(0, 8, 0);
        check_eq("t4_level8", bus.level, 8);
        check_eq("t4_empty", bus.empty, 0);
        check_eq("t4_ae", bus.almost_empty, 0);
        for (int i = 0; i < 8; i++) begin
            check_eq("t4_addr_seq", bus.rd_addr, i);
            step(1, 8, 0);
        end
        check_eq("t4_addr_end", bus.rd_addr, 0);
        check_eq("t4_gray_end", bus.rd_ptr_gray, 4'b1100);
        check_eq("t4_empty_end", bus.empty, 1);

        // Randomized streaming with wrap, writer never overfills
        for (int c = 0; c < 800; c++) begin
            if (c < 200)      rd = ($urandom % 3) == 0;
            else if (c < 400) rd = ($urandom % 3) != 0;
            else              rd = $urandom % 2;
            inc = $urandom % 2;
            clr = ($urandom % 6) == 0;
            wc  = m_wc;
            if (inc && (((m_wc - m_rd) & 15) < DEPTH)) wc = (m_wc + 1) & 15;
            step(rd, wc, clr);
        end

        // Drain to verify last-entry read
        repeat (SS + 1) step(0, m_wc, 0);
        while (!m_empty && n_cmp < 20000) step(1, m_wc, 0);
        check_eq("drain_empty", bus.empty, 1);
        check_eq("drain_level", bus.level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
